// File: rtl/bd_adc_sequencer_if.sv
// ADC handshake and data-bank bundle for the bd_adc_sequencer.
// master = sequencer side, slave = ADC front end plus bank readers.
interface bd_adc_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              adc_start;
  logic              adc_ch_sel;
  logic              adc_done;
  logic [DATA_W-1:0] conversor_adc;
  logic [DATA_W-1:0] BD_DATA_0;
  logic [DATA_W-1:0] BD_DATA_1;
  logic              bd_valid_0;
  logic              bd_valid_1;
  logic              rd_ack_0;
  logic              rd_ack_1;
  logic              overrun_0;
  logic              overrun_1;
  logic              timeout_err;

  modport master (
    output adc_start,
    output adc_ch_sel,
    input  adc_done,
    input  conversor_adc,
    output BD_DATA_0,
    output BD_DATA_1,
    output bd_valid_0,
    output bd_valid_1,
    input  rd_ack_0,
    input  rd_ack_1,
    output overrun_0,
    output overrun_1,
    output timeout_err
  );

  modport slave (
    input  adc_start,
    input  adc_ch_sel,
    output adc_done,
    output conversor_adc,
    input  BD_DATA_0,
    input  BD_DATA_1,
    input  bd_valid_0,
    input  bd_valid_1,
    output rd_ack_0,
    output rd_ack_1,
    input  overrun_0,
    input  overrun_1,
    input  timeout_err
  );
endinterface

// File: rtl/bd_adc_sequencer.sv
// Two-channel ADC sequencer: periodic alternating conversions
// feeding the BD_DATA_0/1 bank with fresh, overrun and timeout flags.
module bd_adc_sequencer #(
  parameter int DATA_W     = 8,
  parameter int SAMPLE_DIV = 16,
  parameter int TIMEOUT    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               clr_err,
  bd_adc_sequencer_if.master bus
);

  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    START,
    CONVERT
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [TW-1:0]     tick_cnt;
  logic [CW-1:0]     to_cnt;
  logic              ch;
  logic              tick;
  logic              start_o;
  logic              sel_o;
  logic              store;
  logic              expire;
  logic              conv_end;
  logic              st_0;
  logic              st_1;
  logic [DATA_W-1:0] data_0;
  logic [DATA_W-1:0] data_1;
  logic              valid_0;
  logic              valid_1;
  logic              ovr_0;
  logic              ovr_1;
  logic              to_err;

  assign tick = enable && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_comb begin
    state_nx = state;
    start_o  = 1'b0;
    sel_o    = 1'b0;
    store    = 1'b0;
    expire   = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) state_nx = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (!enable)   state_nx = IDLE;
        else if (tick) state_nx = START;
      end
      START: begin
        start_o  = 1'b1;
        sel_o    = ch;
        state_nx = CONVERT;
      end
      CONVERT: begin
        sel_o = ch;
        // done on the last allowed cycle still wins over timeout
        if (bus.adc_done)          store  = 1'b1;
        else if (to_cnt == TO_LAST) expire = 1'b1;
        if (store || expire)
          state_nx = enable ? WAIT_TICK : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign conv_end = store | expire;
  assign st_0     = store & ~ch;
  assign st_1     = store & ch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ch     <= 1'b0;
      to_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == START)
        to_cnt <= '0;
      else if (state == CONVERT && !conv_end)
        to_cnt <= to_cnt + CW'(1);
      if (conv_end)
        ch <= ~ch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_0  <= '0;
      data_1  <= '0;
      valid_0 <= 1'b0;
      valid_1 <= 1'b0;
      ovr_0   <= 1'b0;
      ovr_1   <= 1'b0;
      to_err  <= 1'b0;
    end else begin
      if (st_0) data_0 <= bus.conversor_adc;
      if (st_1) data_1 <= bus.conversor_adc;

      if (st_0)              valid_0 <= 1'b1;
      else if (bus.rd_ack_0) valid_0 <= 1'b0;
      if (st_1)              valid_1 <= 1'b1;
      else if (bus.rd_ack_1) valid_1 <= 1'b0;

      // a fresh error event beats a same-cycle clear
      if (st_0 && valid_0 && !bus.rd_ack_0) ovr_0 <= 1'b1;
      else if (clr_err)                     ovr_0 <= 1'b0;
      if (st_1 && valid_1 && !bus.rd_ack_1) ovr_1 <= 1'b1;
      else if (clr_err)                     ovr_1 <= 1'b0;

      if (expire)       to_err <= 1'b1;
      else if (clr_err) to_err <= 1'b0;
    end
  end

  assign bus.adc_start   = start_o;
  assign bus.adc_ch_sel  = sel_o;
  assign bus.BD_DATA_0   = data_0;
  assign bus.BD_DATA_1   = data_1;
  assign bus.bd_valid_0  = valid_0;
  assign bus.bd_valid_1  = valid_1;
  assign bus.overrun_0   = ovr_0;
  assign bus.overrun_1   = ovr_1;
  assign bus.timeout_err = to_err;

endmodule
